// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared state encoding, counter width and byte-mask helper for memory_wait_pipe
package memory_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_WAIT   = 2'd1,
        MEM_ACCESS = 2'd2
    } mem_state_t;

    localparam int WS_CWIDTH   = 4;
    // Widest byte-lane count the helper supports; callers zero-extend and truncate.
    localparam int MAX_BEWIDTH = 32;

    // Expands each byte-enable bit into a full byte of mask bits.
    function automatic logic [MAX_BEWIDTH*8-1:0] be_to_mask(input logic [MAX_BEWIDTH-1:0] i_be);
        logic [MAX_BEWIDTH*8-1:0] w_mask;
        for (int k = 0; k < MAX_BEWIDTH; k++) begin
            w_mask[8*k +: 8] = {8{i_be[k]}};
        end
        return w_mask;
    endfunction

endpackage

// File: rtl/memory_wait_pipe_if.sv
// rtl/memory_wait_pipe_if.sv - cyc/stb/we/ack/stall data-port bus between core and memory_wait_pipe
interface memory_wait_pipe_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    localparam int BEWIDTH = DWIDTH / 8;

    logic               m_i_cyc;
    logic               m_i_stb;
    logic               m_i_we;
    logic               m_i_rd;
    logic [BEWIDTH-1:0] m_i_byte_enable;
    logic [AWIDTH-1:0]  m_i_load_addr;
    logic [AWIDTH-1:0]  m_i_store_addr;
    logic [DWIDTH-1:0]  m_i_data_store;
    logic [DWIDTH-1:0]  m_o_read_data;
    logic               m_o_ack;
    logic               m_o_err;
    logic               m_o_stall;

    modport slave (
        input  m_i_cyc, m_i_stb, m_i_we, m_i_rd, m_i_byte_enable,
        input  m_i_load_addr, m_i_store_addr, m_i_data_store,
        output m_o_read_data, m_o_ack, m_o_err, m_o_stall
    );

    modport master (
        output m_i_cyc, m_i_stb, m_i_we, m_i_rd, m_i_byte_enable,
        output m_i_load_addr, m_i_store_addr, m_i_data_store,
        input  m_o_read_data, m_o_ack, m_o_err, m_o_stall
    );

endinterface

// File: rtl/memory_byte_merge.sv
// rtl/memory_byte_merge.sv - combinational byte-lane merge of new write data into an old word
module memory_byte_merge
    import memory_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]   i_old,
    input  logic [DWIDTH-1:0]   i_new,
    input  logic [DWIDTH/8-1:0] i_be,
    output logic [DWIDTH-1:0]   o_merged
);
    localparam int BEWIDTH = DWIDTH / 8;

    logic [MAX_BEWIDTH-1:0] w_be_ext;
    logic [DWIDTH-1:0]      w_mask;

    // Widen the enables to the helper's fixed width; unused lanes stay disabled
    always_comb begin
        w_be_ext              = '0;
        w_be_ext[BEWIDTH-1:0] = i_be;
    end

    assign w_mask   = DWIDTH'(be_to_mask(w_be_ext));
    assign o_merged = (i_old & ~w_mask) | (i_new & w_mask);

endmodule

// File: rtl/memory_wait_pipe.sv
// rtl/memory_wait_pipe.sv - wait-state data memory slave; optional MEMORY_BOUND_CHECK_EN adds out-of-range error responses
module memory_wait_pipe
    import memory_pkg::*;
#(
    parameter int AWIDTH      = 5,
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 1 << AWIDTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                m_clk,
    input  logic                m_rst,
    memory_wait_pipe_if.slave   s_bus
);
    localparam int BEWIDTH = DWIDTH / 8;
    // With zero wait states this wraps, but the counter is never consulted then.
    localparam logic [WS_CWIDTH-1:0] CNT_INIT = WS_CWIDTH'(WAIT_STATES - 1);

    mem_state_t           r_state;
    logic [WS_CWIDTH-1:0] r_cnt;
    logic                 r_we;
    logic                 r_rd;
    logic                 r_oob;
    logic [AWIDTH-1:0]    r_ld;
    logic [AWIDTH-1:0]    r_st;
    logic [DWIDTH-1:0]    r_data;
    logic [BEWIDTH-1:0]   r_be;
    logic                 r_ack;
    logic                 r_err;
    logic                 r_stall;
    logic [DWIDTH-1:0]    r_read_data;
    logic [DWIDTH-1:0]    r_mem [DEPTH];

    logic                 w_oob_req;
    logic                 w_wr_fire;
    logic [DWIDTH-1:0]    w_merged;

`ifdef MEMORY_BOUND_CHECK_EN
    localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH + 1)'(DEPTH);
    assign w_oob_req = (s_bus.m_i_we && ({1'b0, s_bus.m_i_store_addr} >= DEPTH_LIM)) ||
                       (s_bus.m_i_rd && ({1'b0, s_bus.m_i_load_addr}  >= DEPTH_LIM));
`else
    assign w_oob_req = 1'b0;
`endif

    // A write lands only on an ACCESS edge that was not aborted and is in range
    assign w_wr_fire = (r_state == MEM_ACCESS) && s_bus.m_i_cyc && r_we && !r_oob;

    memory_byte_merge #(
        .DWIDTH (DWIDTH)
    ) u_merge (
        .i_old    (r_mem[r_st]),
        .i_new    (r_data),
        .i_be     (r_be),
        .o_merged (w_merged)
    );

    // Word storage: cleared on reset, updated with the merged word on a committed write
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[r_st] <= w_merged;
        end
    end

    // Request FSM: accept in IDLE, count wait states, complete or abort, pulse ack/err
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            r_state     <= MEM_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_rd        <= 1'b0;
            r_oob       <= 1'b0;
            r_ld        <= '0;
            r_st        <= '0;
            r_data      <= '0;
            r_be        <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_stall     <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (s_bus.m_i_cyc && s_bus.m_i_stb) begin
                        r_we    <= s_bus.m_i_we;
                        r_rd    <= s_bus.m_i_rd;
                        r_ld    <= s_bus.m_i_load_addr;
                        r_st    <= s_bus.m_i_store_addr;
                        r_data  <= s_bus.m_i_data_store;
                        r_be    <= s_bus.m_i_byte_enable;
                        r_oob   <= w_oob_req;
                        r_cnt   <= CNT_INIT;
                        r_stall <= 1'b1;
                        r_state <= (WAIT_STATES > 0) ? MEM_WAIT : MEM_ACCESS;
                    end
                end
                MEM_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (!s_bus.m_i_cyc) begin
                        r_stall <= 1'b0;
                        r_state <= MEM_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= MEM_ACCESS;
                    end
                end
                MEM_ACCESS: begin
                    r_stall <= 1'b0;
                    r_state <= MEM_IDLE;
                    if (s_bus.m_i_cyc) begin
                        if (r_oob) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ack <= 1'b1;
                            // Nonblocking read returns the word as it was before this edge's write
                            if (r_rd) begin
                                r_read_data <= r_mem[r_ld];
                            end
                        end
                    end
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

    assign s_bus.m_o_ack       = r_ack;
    assign s_bus.m_o_err       = r_err;
    assign s_bus.m_o_stall     = r_stall;
    assign s_bus.m_o_read_data = r_read_data;

endmodule

// File: tb/tb_memory_wait_pipe.sv
// tb/tb_memory_wait_pipe.sv - scoreboard bench for memory_wait_pipe over four wait-state/depth configurations
module tb_memory_wait_pipe;

    localparam int NDUT = 4;
    localparam int LIM  = 24;
`ifdef MEMORY_BOUND_CHECK_EN
    localparam int BC_DEPTH = 20;
`else
    localparam int BC_DEPTH = 32;
`endif

    typedef struct packed {
        logic        is_err;
        logic [31:0] rd;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cyc_cnt = 0;
    int          n_chk   = 0;
    int          n_fail  = 0;

    logic [NDUT-1:0] cyc, stb, we, rd;
    logic [3:0]      be    [NDUT];
    logic [4:0]      ld    [NDUT];
    logic [4:0]      st    [NDUT];
    logic [31:0]     wd    [NDUT];
    logic [NDUT-1:0] ack, err, stall;
    logic [31:0]     rdata [NDUT];

    exp_t exp_q [NDUT][$];
    int   st_cnt [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        memory_wait_pipe_if #(.AWIDTH(5), .DWIDTH(32)) bus ();

        memory_wait_pipe #(
            .AWIDTH      (5),
            .DWIDTH      (32),
            .DEPTH       ((g == 3) ? BC_DEPTH : 32),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 2 : 1)
        ) u_dut (
            .m_clk (clk),
            .m_rst (rst_n),
            .s_bus (bus)
        );

        assign bus.m_i_cyc         = cyc[g];
        assign bus.m_i_stb         = stb[g];
        assign bus.m_i_we          = we[g];
        assign bus.m_i_rd          = rd[g];
        assign bus.m_i_byte_enable = be[g];
        assign bus.m_i_load_addr   = ld[g];
        assign bus.m_i_store_addr  = st[g];
        assign bus.m_i_data_store  = wd[g];
        assign ack[g]              = bus.m_o_ack;
        assign err[g]              = bus.m_o_err;
        assign stall[g]            = bus.m_o_stall;
        assign rdata[g]            = bus.m_o_read_data;
    end

    function automatic int ws_of(input int g);
        case (g)
            0:       return 0;
            1:       return 3;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%08h required 0x%08h", name, g, act, exp_v);
        end
    endtask

    // Response monitor: pops the scoreboard on every ack/err and counts stall cycles per request
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (ack[k] || err[k]) begin
                chk("ack_err_exclusive", k, {31'd0, ack[k] & err[k]}, 32'd0);
                if (exp_q[k].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_response dut%0d: got ack=%0b err=%0b required none", k, ack[k], err[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    chk("resp_is_err", k, {31'd0, err[k]}, {31'd0, e.is_err});
                    chk("resp_cycle", k, cyc_cnt, e.cyc);
                    chk("read_data", k, rdata[k], e.rd);
                    chk("stall_cycles", k, st_cnt[k], ws_of(k) + 1);
                end
                st_cnt[k] = 0;
            end else if (stall[k]) begin
                st_cnt[k] = st_cnt[k] + 1;
            end else begin
                st_cnt[k] = 0;
            end
        end
    end

    task automatic drive(input int g, input logic i_we, input logic i_rd, input logic [3:0] i_be,
                         input logic [4:0] i_ld, input logic [4:0] i_st, input logic [31:0] i_d);
        we[g] = i_we;
        rd[g] = i_rd;
        be[g] = i_be;
        ld[g] = i_ld;
        st[g] = i_st;
        wd[g] = i_d;
    endtask

    task automatic expect_resp(input int g, input logic is_err, input logic [31:0] rdv, input int at);
        exp_t e;
        e.is_err = is_err;
        e.rd     = rdv;
        e.cyc    = at;
        exp_q[g].push_back(e);
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (!(ack[g] || err[g]) && n < LIM) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= LIM) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout dut%0d: no response within %0d cycles", g, LIM);
        end
    endtask

    // One request; expected response lands W+2 edges after the cycle it is driven in
    task automatic req(input int g, input logic i_we, input logic i_rd, input logic [3:0] i_be,
                       input logic [4:0] i_ld, input logic [4:0] i_st, input logic [31:0] i_d,
                       input logic is_err, input logic [31:0] rdv);
        drive(g, i_we, i_rd, i_be, i_ld, i_st, i_d);
        stb[g] = 1'b1;
        expect_resp(g, is_err, rdv, cyc_cnt + ws_of(g) + 2);
        @(posedge clk);
        #1;
        stb[g] = 1'b0;
        wait_done(g);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        cyc   = '0;
        stb   = '0;
        we    = '0;
        rd    = '0;
        for (int k = 0; k < NDUT; k++) begin
            be[k] = '0; ld[k] = '0; st[k] = '0; wd[k] = '0; st_cnt[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_ack", k, {31'd0, ack[k]}, 32'd0);
            chk("reset_err", k, {31'd0, err[k]}, 32'd0);
            chk("reset_stall", k, {31'd0, stall[k]}, 32'd0);
            chk("reset_read_data", k, rdata[k], 32'd0);
        end
        rst_n = 1'b1;
        cyc   = '1;
        @(posedge clk);
        #1;

        // Zero wait states: full write, byte lanes, read-before-write, idle request
        req(0, 1, 0, 4'hF, 5'd0, 5'd3, 32'hDEADBEEF, 0, 32'h00000000);
        req(0, 0, 1, 4'h0, 5'd3, 5'd0, 32'h0,        0, 32'hDEADBEEF);
        req(0, 1, 0, 4'hF, 5'd0, 5'd5, 32'h11223344, 0, 32'hDEADBEEF);
        req(0, 1, 0, 4'h5, 5'd0, 5'd5, 32'hAABBCCDD, 0, 32'hDEADBEEF);
        req(0, 0, 1, 4'h0, 5'd5, 5'd0, 32'h0,        0, 32'h11BB33DD);
        req(0, 1, 0, 4'hF, 5'd0, 5'd7, 32'h12345678, 0, 32'h11BB33DD);
        req(0, 1, 1, 4'hF, 5'd7, 5'd7, 32'h0000FFFF, 0, 32'h12345678);
        req(0, 0, 0, 4'hF, 5'd7, 5'd7, 32'hFFFFFFFF, 0, 32'h12345678);
        req(0, 0, 1, 4'h0, 5'd7, 5'd0, 32'h0,        0, 32'h0000FFFF);

        // Three wait states, then a back-to-back pair with stb held across the ack edge
        req(1, 1, 0, 4'hF, 5'd0, 5'd2, 32'h0BADF00D, 0, 32'h00000000);
        c0 = cyc_cnt;
        drive(1, 0, 1, 4'h0, 5'd2, 5'd0, 32'h0);
        stb[1] = 1'b1;
        expect_resp(1, 0, 32'h0BADF00D, c0 + 5);
        expect_resp(1, 0, 32'h00000000, c0 + 10);
        @(posedge clk);
        #1;
        drive(1, 1, 1, 4'hF, 5'd9, 5'd9, 32'h01020304);
        wait_done(1);
        @(posedge clk);
        #1;
        stb[1] = 1'b0;
        wait_done(1);
        req(1, 0, 1, 4'h0, 5'd9, 5'd0, 32'h0, 0, 32'h01020304);

        // Two wait states: abort a write by dropping cyc in WAIT
        req(2, 1, 0, 4'hF, 5'd0, 5'd1, 32'hCAFEF00D, 0, 32'h00000000);
        drive(2, 1, 0, 4'hF, 5'd0, 5'd1, 32'h55555555);
        stb[2] = 1'b1;
        @(posedge clk);
        #1;
        stb[2] = 1'b0;
        cyc[2] = 1'b0;
        chk("abort_stall_in_wait", 2, {31'd0, stall[2]}, 32'd1);
        @(posedge clk);
        #1;
        chk("abort_stall_low", 2, {31'd0, stall[2]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_ack", 2, {31'd0, ack[2]}, 32'd0);
        end
        cyc[2] = 1'b1;
        req(2, 0, 1, 4'h0, 5'd1, 5'd0, 32'h0, 0, 32'hCAFEF00D);

`ifdef MEMORY_BOUND_CHECK_EN
        // DEPTH=20: top word works, addresses 20 and above raise err
        req(3, 1, 0, 4'hF, 5'd0,  5'd19, 32'h00000077, 0, 32'h00000000);
        req(3, 1, 0, 4'hF, 5'd0,  5'd25, 32'h99999999, 1, 32'h00000000);
        req(3, 1, 0, 4'hF, 5'd0,  5'd20, 32'h88888888, 1, 32'h00000000);
        req(3, 0, 1, 4'h0, 5'd19, 5'd0,  32'h0,        0, 32'h00000077);
        req(3, 0, 1, 4'h0, 5'd25, 5'd0,  32'h0,        1, 32'h00000077);
`else
        req(3, 1, 0, 4'hF, 5'd0,  5'd25, 32'h99999999, 0, 32'h00000000);
        req(3, 1, 0, 4'h3, 5'd0,  5'd31, 32'hA5A5A5A5, 0, 32'h00000000);
        req(3, 0, 1, 4'h0, 5'd25, 5'd0,  32'h0,        0, 32'h99999999);
        req(3, 0, 1, 4'h0, 5'd31, 5'd0,  32'h0,        0, 32'h0000A5A5);
`endif

        // Asynchronous reset in the middle of a WAIT
        drive(1, 1, 0, 4'hF, 5'd0, 5'd2, 32'h77777777);
        stb[1] = 1'b1;
        @(posedge clk);
        #1;
        stb[1] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", 1, {31'd0, stall[1]}, 32'd0);
        chk("midreset_ack", 1, {31'd0, ack[1]}, 32'd0);
        chk("midreset_err", 1, {31'd0, err[1]}, 32'd0);
        chk("midreset_read_data", 1, rdata[1], 32'd0);
        chk("midreset_read_data", 0, rdata[0], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(1, 0, 1, 4'h0, 5'd2, 5'd0, 32'h0, 0, 32'h00000000);
        req(0, 0, 1, 4'h0, 5'd3, 5'd0, 32'h0, 0, 32'h00000000);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("queue_drained", k, exp_q[k].size(), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
